// File: rtl/video_mon_pkg.sv
`default_nettype none
// video_mon_pkg: shared count type, FSM state codes, error bit indices and
// saturating-count helpers for video_timing_monitor. Rev 1.0
package video_mon_pkg;

    typedef logic [15:0] count_t;

    localparam count_t CNT_MAX = 16'hFFFF;

    localparam int         STATE_W    = 2;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACQUIRE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam int ERR_H_TOTAL  = 0;
    localparam int ERR_HS_WIDTH = 1;
    localparam int ERR_H_ACTIVE = 2;
    localparam int ERR_V_TOTAL  = 3;
    localparam int ERR_VS_WIDTH = 4;
    localparam int ERR_V_ACTIVE = 5;
    localparam int ERR_W        = 6;

    function automatic count_t sat_inc(input count_t c);
        return (c == CNT_MAX) ? c : c + 16'd1;
    endfunction

    // A saturated count can no longer be trusted, so it always mismatches.
    function automatic logic cnt_bad(input count_t c, input count_t expv);
        return (c != expv) || (c == CNT_MAX);
    endfunction

endpackage
`default_nettype wire

// File: rtl/video_timing_monitor_edge_meter.sv
`default_nettype none
// edge_meter: period and low-width counter for one active-low strobe,
// counting tick_i events with saturation. Rev 1.0
module edge_meter
    import video_mon_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fall_i,
    input  logic        rise_i,
    input  logic        low_i,
    input  logic        tick_i,
    output logic [15:0] period_o,
    output logic [15:0] width_o,
    output logic        started_o,
    output logic        rise_o
);

    count_t period_q, period_d;
    count_t width_q,  width_d;
    logic   started_q, started_d;

    // A tick coinciding with the falling edge belongs to the new period.
    always_comb begin
        period_d  = period_q;
        width_d   = width_q;
        started_d = started_q;
        if (fall_i) begin
            period_d  = {15'd0, tick_i};
            width_d   = {15'd0, tick_i};
            started_d = 1'b1;
        end else begin
            if (tick_i) begin
                period_d = sat_inc(period_q);
            end
            if (tick_i && low_i) begin
                width_d = sat_inc(width_q);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            period_q  <= '0;
            width_q   <= '0;
            started_q <= 1'b0;
        end else begin
            period_q  <= period_d;
            width_q   <= width_d;
            started_q <= started_d;
        end
    end

    assign period_o  = period_q;
    assign width_o   = width_q;
    assign started_o = started_q;
    assign rise_o    = rise_i;

endmodule
`default_nettype wire

// File: rtl/video_timing_monitor.sv
`default_nettype none
// video_timing_monitor: passive HS/VS/BLANK timing checker with sticky error
// flags, lock indication and per-frame active-pixel checksum. Rev 1.0
module video_timing_monitor
    import video_mon_pkg::*;
#(
    parameter int HDISP  = 800,
    parameter int VDISP  = 480,
    parameter int HTOTAL = 928,
    parameter int VTOTAL = 525,
    parameter int HPULSE = 48,
    parameter int VPULSE = 3
) (
    input  logic        pixel_clk,
    input  logic        pixel_rst,
    input  logic        video_hs_i,
    input  logic        video_vs_i,
    input  logic        video_blank_i,
    input  logic [23:0] video_rgb_i,
    input  logic        err_clr,
    output logic [5:0]  err,
    output logic        locked,
    output logic        frame_done,
    output logic [15:0] frame_cnt,
    output logic [31:0] frame_sum,
    output logic [15:0] meas_htotal,
    output logic [15:0] meas_hactive,
    output logic [15:0] meas_vtotal,
    output logic [15:0] meas_vactive
);

    localparam count_t HDISP_C  = count_t'(HDISP);
    localparam count_t VDISP_C  = count_t'(VDISP);
    localparam count_t HTOTAL_C = count_t'(HTOTAL);
    localparam count_t VTOTAL_C = count_t'(VTOTAL);
    localparam count_t HPULSE_C = count_t'(HPULSE);
    localparam count_t VPULSE_C = count_t'(VPULSE);

    logic        hs_s1_q, hs_s2_q, vs_s1_q, vs_s2_q, blank_s1_q;
    logic [23:0] rgb_s1_q;
    logic [1:0]  vld_q;

    // Stage 2 only holds real bus data two cycles after reset; until then no
    // edges are reported so a strobe already low at reset is not a false fall.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            hs_s1_q    <= 1'b1;
            hs_s2_q    <= 1'b1;
            vs_s1_q    <= 1'b1;
            vs_s2_q    <= 1'b1;
            blank_s1_q <= 1'b0;
            rgb_s1_q   <= '0;
            vld_q      <= '0;
        end else begin
            hs_s1_q    <= video_hs_i;
            hs_s2_q    <= hs_s1_q;
            vs_s1_q    <= video_vs_i;
            vs_s2_q    <= vs_s1_q;
            blank_s1_q <= video_blank_i;
            rgb_s1_q   <= video_rgb_i;
            vld_q      <= {vld_q[0], 1'b1};
        end
    end

    logic hs_fall, hs_rise, vs_fall, vs_rise;
    assign hs_fall = vld_q[1] & ~hs_s1_q &  hs_s2_q;
    assign hs_rise = vld_q[1] &  hs_s1_q & ~hs_s2_q;
    assign vs_fall = vld_q[1] & ~vs_s1_q &  vs_s2_q;
    assign vs_rise = vld_q[1] &  vs_s1_q & ~vs_s2_q;

    logic [15:0] h_period, h_width, v_period, v_width;
    logic        h_started, v_started, hs_rise_m, vs_rise_m;

    edge_meter u_hs_meter (
        .clk_i     (pixel_clk),
        .rst_i     (pixel_rst),
        .fall_i    (hs_fall),
        .rise_i    (hs_rise),
        .low_i     (~hs_s1_q),
        .tick_i    (1'b1),
        .period_o  (h_period),
        .width_o   (h_width),
        .started_o (h_started),
        .rise_o    (hs_rise_m)
    );

    edge_meter u_vs_meter (
        .clk_i     (pixel_clk),
        .rst_i     (pixel_rst),
        .fall_i    (vs_fall),
        .rise_i    (vs_rise),
        .low_i     (~vs_s1_q),
        .tick_i    (hs_fall),
        .period_o  (v_period),
        .width_o   (v_width),
        .started_o (v_started),
        .rise_o    (vs_rise_m)
    );

    count_t      hact_q, hact_d, vact_q, vact_d;
    logic [31:0] sum_q, sum_d;
    logic        line_act;

    assign line_act = hs_fall & h_started & (hact_q != 16'd0);

    always_comb begin
        hact_d = hact_q;
        vact_d = vact_q;
        sum_d  = sum_q;
        if (hs_fall) begin
            hact_d = {15'd0, blank_s1_q};
        end else if (blank_s1_q) begin
            hact_d = sat_inc(hact_q);
        end
        if (vs_fall) begin
            vact_d = {15'd0, line_act};
            sum_d  = blank_s1_q ? {8'd0, rgb_s1_q} : 32'd0;
        end else begin
            if (line_act) begin
                vact_d = sat_inc(vact_q);
            end
            if (blank_s1_q) begin
                sum_d = sum_q + {8'd0, rgb_s1_q};
            end
        end
    end

    logic [STATE_W-1:0] state_q, state_d;
    logic               clean_q, clean_d;
    logic [ERR_W-1:0]   mism;
    logic               cmp_en;

    assign cmp_en = (state_q != ST_IDLE);

    always_comb begin
        mism               = '0;
        mism[ERR_H_TOTAL]  = cmp_en & hs_fall & h_started & cnt_bad(h_period, HTOTAL_C);
        mism[ERR_HS_WIDTH] = cmp_en & hs_rise_m & h_started & cnt_bad(h_width, HPULSE_C);
        mism[ERR_H_ACTIVE] = cmp_en & hs_fall & h_started & (hact_q != 16'd0)
                             & cnt_bad(hact_q, HDISP_C);
        mism[ERR_V_TOTAL]  = cmp_en & vs_fall & v_started & cnt_bad(v_period, VTOTAL_C);
        mism[ERR_VS_WIDTH] = cmp_en & vs_rise_m & v_started & cnt_bad(v_width, VPULSE_C);
        mism[ERR_V_ACTIVE] = cmp_en & vs_fall & v_started & cnt_bad(vact_q, VDISP_C);
    end

    logic [ERR_W-1:0] err_q;
    logic             mism_any_q, frame_done_q;
    logic [15:0]      frame_cnt_q, meas_htotal_q, meas_hactive_q, meas_vtotal_q, meas_vactive_q;
    logic [31:0]      frame_sum_q;

    // A partial frame (first VS fall since reset) reports zero measurements.
    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            hact_q         <= '0;
            vact_q         <= '0;
            sum_q          <= '0;
            err_q          <= '0;
            mism_any_q     <= 1'b0;
            frame_done_q   <= 1'b0;
            frame_cnt_q    <= '0;
            frame_sum_q    <= '0;
            meas_htotal_q  <= '0;
            meas_hactive_q <= '0;
            meas_vtotal_q  <= '0;
            meas_vactive_q <= '0;
        end else begin
            hact_q       <= hact_d;
            vact_q       <= vact_d;
            sum_q        <= sum_d;
            err_q        <= (err_clr ? '0 : err_q) | mism;
            mism_any_q   <= |mism;
            frame_done_q <= vs_fall;
            if (vs_fall) begin
                frame_cnt_q    <= frame_cnt_q + 16'd1;
                frame_sum_q    <= v_started ? sum_q    : 32'd0;
                meas_vtotal_q  <= v_started ? v_period : 16'd0;
                meas_vactive_q <= v_started ? vact_q   : 16'd0;
            end
            if (hs_fall && h_started) begin
                meas_htotal_q  <= h_period;
                meas_hactive_q <= hact_q;
            end
        end
    end

    // Lock needs one whole frame without a mismatch; clean re-arms every frame.
    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_done_q) begin
                    state_d = ST_ACQUIRE;
                    clean_d = 1'b1;
                end
            end
            ST_ACQUIRE: begin
                if (frame_done_q) begin
                    if (clean_q && !mism_any_q) begin
                        state_d = ST_LOCKED;
                    end
                    clean_d = 1'b1;
                end else if (mism_any_q) begin
                    clean_d = 1'b0;
                end
            end
            ST_LOCKED: begin
                if (mism_any_q) begin
                    state_d = ST_ACQUIRE;
                    clean_d = frame_done_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                clean_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state_q <= ST_IDLE;
            clean_q <= 1'b0;
        end else begin
            state_q <= state_d;
            clean_q <= clean_d;
        end
    end

    assign err          = err_q;
    assign locked       = (state_q == ST_LOCKED);
    assign frame_done   = frame_done_q;
    assign frame_cnt    = frame_cnt_q;
    assign frame_sum    = frame_sum_q;
    assign meas_htotal  = meas_htotal_q;
    assign meas_hactive = meas_hactive_q;
    assign meas_vtotal  = meas_vtotal_q;
    assign meas_vactive = meas_vactive_q;

endmodule
`default_nettype wire

// File: tb/tb_video_timing_monitor.sv
`default_nettype none
// tb_video_timing_monitor: directed bench driving a reduced-size timing
// generator (16x6 active, 28x12 total, HS pulse 4, VS pulse 2).
module tb_video_timing_monitor;

    localparam int HD = 16, VD = 6, HT = 28, VT = 12, HP = 4, VP = 2;
    localparam int HS0 = 19;
    localparam int VS0 = 8;
    localparam logic [23:0] RGB_ACT  = 24'h010203;
    localparam logic [23:0] RGB_IDLE = 24'hABCDEF;
    localparam logic [31:0] SUM_EXP  = 32'h0060C120;

    logic        clk = 1'b0;
    logic        rst;
    logic        hs, vs, blank;
    logic [23:0] rgb;
    logic        err_clr;
    logic [5:0]  err;
    logic        locked, frame_done;
    logic [15:0] frame_cnt, meas_htotal, meas_hactive, meas_vtotal, meas_vactive;
    logic [31:0] frame_sum;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    video_timing_monitor #(
        .HDISP(HD), .VDISP(VD), .HTOTAL(HT), .VTOTAL(VT), .HPULSE(HP), .VPULSE(VP)
    ) dut (
        .pixel_clk     (clk),
        .pixel_rst     (rst),
        .video_hs_i    (hs),
        .video_vs_i    (vs),
        .video_blank_i (blank),
        .video_rgb_i   (rgb),
        .err_clr       (err_clr),
        .err           (err),
        .locked        (locked),
        .frame_done    (frame_done),
        .frame_cnt     (frame_cnt),
        .frame_sum     (frame_sum),
        .meas_htotal   (meas_htotal),
        .meas_hactive  (meas_hactive),
        .meas_vtotal   (meas_vtotal),
        .meas_vactive  (meas_vactive)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One bus cycle, driven on the falling clock edge.
    task automatic gen_cycle(input int vc, input int hc, input int hs0, input int hsl);
        @(negedge clk);
        hs    = !(hc >= hs0 && hc < hs0 + hsl);
        vs    = !(vc >= VS0 && vc < VS0 + VP);
        blank = (hc < HD) && (vc < VD);
        rgb   = blank ? RGB_ACT : RGB_IDLE;
    endtask

    task automatic gen_line(input int vc, input int h0, input int ht, input int hs0, input int hsl);
        for (int hc = h0; hc < ht; hc++) begin
            gen_cycle(vc, hc, hs0, hsl);
        end
    endtask

    task automatic gen_lines(input int v0, input int v1);
        for (int vc = v0; vc < v1; vc++) begin
            gen_line(vc, 0, HT, HS0, HP);
        end
    endtask

    initial begin
        rst = 1'b1; hs = 1'b1; vs = 1'b1; blank = 1'b0; rgb = '0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_err",        32'(err),          0);
        chk("rst_locked",     32'(locked),       0);
        chk("rst_frame_done", 32'(frame_done),   0);
        chk("rst_frame_cnt",  32'(frame_cnt),    0);
        chk("rst_frame_sum",  frame_sum,         0);
        chk("rst_meas_ht",    32'(meas_htotal),  0);
        chk("rst_meas_vt",    32'(meas_vtotal),  0);
        rst = 1'b0;

        // Frame 1: first VS fall leaves IDLE.
        gen_lines(0, VT);
        chk("f1_frame_cnt", 32'(frame_cnt), 1);
        chk("f1_locked",    32'(locked),    0);
        chk("f1_err",       32'(err),       0);

        // Frame 2: second VS fall, cycle-exact latency and lock.
        gen_lines(0, VS0);
        gen_cycle(VS0, 0, HS0, HP);
        gen_cycle(VS0, 1, HS0, HP);
        chk("f2_fd_n1", 32'(frame_done), 0);
        gen_cycle(VS0, 2, HS0, HP);
        chk("f2_fd_n2",     32'(frame_done),   1);
        chk("f2_lock_n2",   32'(locked),       0);
        chk("f2_frame_cnt", 32'(frame_cnt),    2);
        chk("f2_frame_sum", frame_sum,         SUM_EXP);
        chk("f2_meas_vt",   32'(meas_vtotal),  VT);
        chk("f2_meas_va",   32'(meas_vactive), VD);
        gen_cycle(VS0, 3, HS0, HP);
        chk("f2_fd_n3",   32'(frame_done), 0);
        chk("f2_lock_n3", 32'(locked),     1);
        gen_line(VS0, 4, HT, HS0, HP);
        gen_lines(VS0 + 1, VT);
        chk("f2_err",     32'(err),         0);
        chk("f2_meas_ht", 32'(meas_htotal), HT);

        // Frame 3: one line one cycle short while locked.
        gen_lines(0, 3);
        chk("f3_meas_ha", 32'(meas_hactive), HD);
        gen_lines(3, 4);
        gen_line(4, 0, HT - 1, HS0, HP);
        gen_lines(5, 6);
        chk("f3_short_err",  32'(err),         32'h01);
        chk("f3_short_lock", 32'(locked),      0);
        chk("f3_short_ht",   32'(meas_htotal), HT - 1);
        gen_lines(6, VT);
        chk("f3_end_lock", 32'(locked), 0);

        // Frame 4: one clean frame relocks; error stays sticky.
        gen_lines(0, VT);
        chk("f4_lock",      32'(locked),    1);
        chk("f4_err",       32'(err),       32'h01);
        chk("f4_frame_sum", frame_sum,      SUM_EXP);
        chk("f4_frame_cnt", 32'(frame_cnt), 4);

        // Frame 5: plain clear, then clear coinciding with an hs_width mismatch.
        err_clr = 1'b1;
        gen_cycle(0, 0, HS0, HP);
        err_clr = 1'b0;
        gen_line(0, 1, HT, HS0, HP);
        chk("f5_clr_err", 32'(err), 0);
        gen_line(1, 0, 25, HS0, HP + 1);
        gen_cycle(1, 25, HS0, HP + 1);
        err_clr = 1'b1;
        gen_cycle(1, 26, HS0, HP + 1);
        err_clr = 1'b0;
        gen_line(1, 27, HT, HS0, HP + 1);
        chk("f5_clr_same_err",  32'(err),    32'h02);
        chk("f5_clr_same_lock", 32'(locked), 0);
        gen_lines(2, VT);

        // Frame 6 relocks, then HS held high long enough to saturate.
        gen_lines(0, VT - 1);
        chk("f6_lock", 32'(locked), 1);
        gen_line(VT - 1, 0, 65600, 0, 0);
        gen_lines(0, 1);
        chk("f7_sat_ht",  32'(meas_htotal), 32'hFFFF);
        chk("f7_sat_err", 32'(err),         32'h03);
        chk("f7_sat_lock", 32'(locked),     0);

        // Frame 7: reset mid-frame.
        gen_lines(1, 3);
        gen_line(3, 0, 10, HS0, HP);
        rst = 1'b1;
        gen_cycle(3, 10, HS0, HP);
        gen_cycle(3, 11, HS0, HP);
        chk("mrst_err",       32'(err),          0);
        chk("mrst_locked",    32'(locked),       0);
        chk("mrst_frame_cnt", 32'(frame_cnt),    0);
        chk("mrst_frame_sum", frame_sum,         0);
        chk("mrst_meas_ht",   32'(meas_htotal),  0);
        chk("mrst_meas_ha",   32'(meas_hactive), 0);
        rst = 1'b0;
        gen_line(3, 12, HT, HS0, HP);
        gen_lines(4, VT);
        chk("f7_frame_cnt", 32'(frame_cnt), 1);
        chk("f7_locked",    32'(locked),    0);

        // Frame 8: first full frame after reset locks cleanly.
        gen_lines(0, VT);
        chk("f8_frame_cnt", 32'(frame_cnt),   2);
        chk("f8_locked",    32'(locked),      1);
        chk("f8_err",       32'(err),         0);
        chk("f8_meas_vt",   32'(meas_vtotal), VT);
        chk("f8_frame_sum", frame_sum,        SUM_EXP);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/video_timing_monitor.md
# video_timing_monitor

Passive checker on the `video_if` bus, directly downstream of the VGA timing/test-pattern generator in the `pixel_clk` domain. It measures horizontal and vertical timing from HS/VS/BLANK and compares each measurement with its parameter. It reports sticky mismatch flags and a lock indication, and accumulates a per-frame checksum of active RGB pixels. The bench and the on-board status registers use it to confirm the generator before the HDMI transmitter is trusted.

## Interface
- `HDISP`, 800, active pixels per line
- `VDISP`, 480, active lines per frame
- `HTOTAL`, 928, pixel clocks per line
- `VTOTAL`, 525, lines per frame
- `HPULSE`, 48, HS low width in pixel clocks
- `VPULSE`, 3, VS low width in lines
- `pixel_clk`  in  1  pixel clock, the only clock
- `pixel_rst`  in  1  synchronous, active-high reset
- `video_ifs`  video_if.slave  —  monitored bus: HS, VS (active-low), BLANK (1 = active pixel), RGB[23:0]
- `err_clr`  in  1  one-cycle pulse, clears `err`
- `err`  out  6  sticky flags: [0] h_total, [1] hs_width, [2] h_active, [3] v_total, [4] vs_width, [5] v_active
- `locked`  out  1  timing matched for one full frame
- `frame_done`  out  1  one-cycle pulse per frame
- `frame_cnt`  out  16  frames seen, wraps
- `frame_sum`  out  32  checksum of the last complete frame
- `meas_htotal`, `meas_hactive`  out  16  last line measurements
- `meas_vtotal`, `meas_vactive`  out  16  last frame measurements

## Operation
- All bus inputs are registered once. Edges are detected against a second register stage.
- **Line counters:** run between consecutive HS falling edges.
  - h_total = cycles from one HS falling edge to the next.
  - hs_width = cycles with HS low, compared on the HS rising edge.
  - h_active = BLANK-high cycles in the line. Compared only if nonzero.
- **Frame counters:** run between consecutive VS falling edges.
  - v_total = HS falling edges counted between VS falling edges.
  - vs_width = HS falling edges while VS low, compared on the VS rising edge.
  - v_active = lines with nonzero h_active.
- All counters are 16 bit and saturate at 0xFFFF. A saturated count mismatches at its next compare.
- **Checksum:** `frame_sum` accumulates RGB as a 24-bit unsigned value on every BLANK-high cycle, modulo 2^32. It is latched and cleared on VS fall.
- **State machine:**
  - IDLE: no compares. The first VS fall goes to ACQUIRE.
  - ACQUIRE: all compares active, except the first h_total/v_total after IDLE, which have no start edge.
  - On VS fall with no mismatch since entering ACQUIRE, go to LOCKED.
  - In LOCKED, any mismatch returns to ACQUIRE.
  - `locked` = (state == LOCKED).
- **Error clear:** a mismatch sets its `err` bit. `err_clr` clears all bits. If a new mismatch occurs in the same cycle as `err_clr`, that bit is set.
- **Frame outputs:** `frame_done`, `frame_cnt` increment, `frame_sum`, `meas_vtotal` and `meas_vactive` update together on VS fall, including the first VS fall out of IDLE.

## Timing
- Reset values:
  - state IDLE, all counters 0
  - `err`=0, `locked`=0, `frame_done`=0, `frame_cnt`=0, `frame_sum`=0
  - all `meas_*` = 0
- Latency: an edge on the bus at cycle n produces updated outputs/`err` at cycle n+2. `locked` changes at n+3.
- Reset mid-frame returns to IDLE. Nothing from the partial frame is reported.
- A simultaneous HS fall and VS fall counts that HS fall in the new frame.

## Structure
- Package `video_mon_pkg`:
  - state enum
  - error bit index constants
  - 16-bit count typedef
- Sub-module `edge_meter`: period and low-width counter for one active-low strobe, with saturation. One instance for HS in cycles, one for VS in HS-edge units.

## Test plan
- Drive the bus from the team's 800x480 generator (928x525, HPULSE 48, VPULSE 3) → `locked`=1 after the 2nd VS fall, `err`=0, `meas_htotal`=928, `meas_vactive`=480.
- Constant RGB 0x010203 over all active pixels → `frame_sum`=0xE7C99400 at each `frame_done`.
- One line shortened to 927 cycles while locked → `err[0]`=1, `locked` drops, and relocks one clean frame later; `err` stays set until `err_clr`.
- HS held high for 70000 cycles → `meas_htotal`=0xFFFF, `err[0]`=1.
- `err_clr` pulsed on the same cycle as a new hs_width mismatch → `err[1]`=1 afterwards.
- `pixel_rst` asserted mid-frame → all outputs at reset values. The next partial frame is ignored, and `frame_cnt`=1 at the first VS fall after reset.
